// File: rtl/fd_arbiter.sv
// ============================================================================
// fd_arbiter : two-master Wishbone arbiter, D priority with fetch anti-starve
// Rev 1.0
// ============================================================================
`default_nettype none

module fd_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        f_cyc_i,
  input  logic [63:2] f_adr_i,
  output logic        f_ack_o,
  output logic [31:0] f_dat_o,
  input  logic        d_cyc_i,
  input  logic        d_we_i,
  input  logic [7:0]  d_sel_i,
  input  logic [63:3] d_adr_i,
  input  logic [63:0] d_dat_i,
  output logic        d_ack_o,
  output logic [63:0] d_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [7:0]  m_sel_o,
  output logic [63:3] m_adr_o,
  output logic [63:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [63:0] m_dat_i
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_F = 2'd1,
    S_BUSY_D = 2'd2
  } owner_t;

  owner_t     r_owner;
  owner_t     w_owner_nxt;
  logic [3:0] r_starve;
  logic       w_sel_f;
  logic       w_sel_d;
  logic       w_cyc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_owner  <= S_IDLE;
      r_starve <= 4'd0;
    end else begin
      r_owner <= w_owner_nxt;
      if (!f_cyc_i || f_ack_o)
        r_starve <= 4'd0;
      else if (r_starve != c_starve_limit)
        r_starve <= r_starve + 4'd1;
    end
  end

  // Selection is live in IDLE; once a transfer is in flight the owner is locked.
  always_comb begin
    w_sel_f     = 1'b0;
    w_sel_d     = 1'b0;
    w_owner_nxt = r_owner;
    case (r_owner)
      S_IDLE: begin
        if (f_cyc_i && (r_starve == c_starve_limit))
          w_sel_f = 1'b1;
        else if (d_cyc_i)
          w_sel_d = 1'b1;
        else if (f_cyc_i)
          w_sel_f = 1'b1;
        if (w_sel_f && !m_ack_i)
          w_owner_nxt = S_BUSY_F;
        else if (w_sel_d && !m_ack_i)
          w_owner_nxt = S_BUSY_D;
      end
      S_BUSY_F: begin
        w_sel_f = 1'b1;
        if (m_ack_i || !f_cyc_i)
          w_owner_nxt = S_IDLE;
      end
      S_BUSY_D: begin
        w_sel_d = 1'b1;
        if (m_ack_i || !d_cyc_i)
          w_owner_nxt = S_IDLE;
      end
      default: w_owner_nxt = S_IDLE;
    endcase
  end

  assign w_cyc = !reset_i && ((w_sel_f && f_cyc_i) || (w_sel_d && d_cyc_i));

  always_comb begin
    m_we_o  = 1'b0;
    m_sel_o = 8'h00;
    m_adr_o = '0;
    m_dat_o = 64'd0;
    if (w_sel_f) begin
      m_sel_o = f_adr_i[2] ? 8'hF0 : 8'h0F;
      m_adr_o = f_adr_i[63:3];
    end else if (w_sel_d) begin
      m_we_o  = d_we_i;
      m_sel_o = d_sel_i;
      m_adr_o = d_adr_i;
      m_dat_o = d_dat_i;
    end
  end

  assign m_cyc_o = w_cyc;
  assign m_stb_o = w_cyc;
  assign f_ack_o = m_ack_i && w_cyc && w_sel_f;
  assign d_ack_o = m_ack_i && w_cyc && w_sel_d;
  assign f_dat_o = f_adr_i[2] ? m_dat_i[63:32] : m_dat_i[31:0];
  assign d_dat_o = m_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_fd_arbiter.sv
// Table-driven bench for fd_arbiter (STARVE_LIMIT = 4).
`default_nettype none

module tb_fd_arbiter;

  localparam logic [1:0] G_N = 2'd0;
  localparam logic [1:0] G_F = 2'd1;
  localparam logic [1:0] G_D = 2'd2;

  localparam logic [61:0] FA   = 62'h3FFF_FFFF_FFFF_FFC1;
  localparam logic [60:0] FA_W = 61'h1FFF_FFFF_FFFF_FFE0;
  localparam logic [61:0] FB   = 62'h0000_0000_0000_1000;
  localparam logic [60:0] FB_W = 61'h0000_0000_0000_0800;
  localparam logic [60:0] DA   = 61'h0000_0000_0000_0ABC;
  localparam logic [7:0]  DSEL = 8'h3C;
  localparam logic [63:0] DD   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] MD   = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        f_cyc_i;
  logic [63:2] f_adr_i;
  logic        f_ack_o;
  logic [31:0] f_dat_o;
  logic        d_cyc_i;
  logic        d_we_i;
  logic [7:0]  d_sel_i;
  logic [63:3] d_adr_i;
  logic [63:0] d_dat_i;
  logic        d_ack_o;
  logic [63:0] d_dat_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [7:0]  m_sel_o;
  logic [63:3] m_adr_o;
  logic [63:0] m_dat_o;
  logic        m_ack_i;
  logic [63:0] m_dat_i;

  always #5 clk_i = ~clk_i;

  fd_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .f_cyc_i (f_cyc_i),
    .f_adr_i (f_adr_i),
    .f_ack_o (f_ack_o),
    .f_dat_o (f_dat_o),
    .d_cyc_i (d_cyc_i),
    .d_we_i  (d_we_i),
    .d_sel_i (d_sel_i),
    .d_adr_i (d_adr_i),
    .d_dat_i (d_dat_i),
    .d_ack_o (d_ack_o),
    .d_dat_o (d_dat_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_ack_i (m_ack_i),
    .m_dat_i (m_dat_i)
  );

  typedef struct {
    logic        rst;
    logic        fc;
    logic [61:0] fa;
    logic        dc;
    logic        dwe;
    logic        ack;
    logic [1:0]  g;     // expected grant
    logic        ecyc;  // expected m_cyc_o
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic add(input logic rst, input logic fc, input logic [61:0] fa,
                     input logic dc, input logic dwe, input logic ack,
                     input logic [1:0] g, input logic ecyc);
    vec_t v;
    v.rst = rst; v.fc = fc; v.fa = fa; v.dc = dc; v.dwe = dwe;
    v.ack = ack; v.g = g; v.ecyc = ecyc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic fc, input logic [61:0] fa,
                       input logic dc, input logic dwe, input logic ack);
    reset_i = rst;
    f_cyc_i = fc;
    f_adr_i = fa;
    d_cyc_i = dc;
    d_we_i  = dwe;
    m_ack_i = ack;
  endtask

  initial begin
    vec_t v;
    d_sel_i = DSEL;
    d_adr_i = DA;
    d_dat_i = DD;
    m_dat_i = MD;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // reset with everything requesting
    add(1, 1, FA, 1, 0, 1, G_N, 0);
    add(1, 1, FA, 1, 0, 1, G_N, 0);
    // both requesting, always-ack slave: D,D,D,D,F twice
    for (int k = 0; k < 10; k++)
      add(0, 1, FA, 1, 0, 1, (k % 5 == 4) ? G_F : G_D, 1);
    // fetch only, upper then lower word
    for (int k = 0; k < 3; k++)
      add(0, 1, FA, 0, 0, 1, G_F, 1);
    add(0, 1, FB, 0, 0, 1, G_F, 1);
    // D write with three wait states, F arrives meanwhile
    add(0, 0, FA, 1, 1, 0, G_D, 1);
    add(0, 1, FA, 1, 1, 0, G_D, 1);
    add(0, 1, FA, 1, 1, 0, G_D, 1);
    add(0, 1, FA, 1, 1, 1, G_D, 1);
    add(0, 1, FA, 0, 0, 1, G_F, 1);
    // F abort while D waits
    add(0, 1, FB, 0, 0, 0, G_F, 1);
    add(0, 0, FB, 1, 0, 0, G_F, 0);
    add(0, 0, FB, 1, 0, 1, G_D, 1);
    // reset in the middle of a D transfer, then starvation restarts from 0
    add(0, 1, FA, 1, 0, 0, G_D, 1);
    add(0, 1, FA, 1, 0, 0, G_D, 1);
    add(1, 1, FA, 1, 0, 1, G_N, 0);
    for (int k = 0; k < 5; k++)
      add(0, 1, FA, 1, 0, 1, (k == 4) ? G_F : G_D, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk_i);
      drive(v.rst, v.fc, v.fa, v.dc, v.dwe, v.ack);
      #1;
      chk($sformatf("r%0d m_cyc", i), 64'(m_cyc_o), 64'(v.ecyc));
      chk($sformatf("r%0d m_stb", i), 64'(m_stb_o), 64'(v.ecyc));
      chk($sformatf("r%0d f_ack", i), 64'(f_ack_o), 64'(v.ecyc && v.ack && v.g == G_F));
      chk($sformatf("r%0d d_ack", i), 64'(d_ack_o), 64'(v.ecyc && v.ack && v.g == G_D));
      chk($sformatf("r%0d d_dat", i), d_dat_o, MD);
      if (v.ecyc && v.g == G_F) begin
        chk($sformatf("r%0d f m_we", i), 64'(m_we_o), 64'd0);
        chk($sformatf("r%0d f m_sel", i), 64'(m_sel_o), v.fa[0] ? 64'hF0 : 64'h0F);
        chk($sformatf("r%0d f m_adr", i), 64'(m_adr_o), v.fa[0] ? 64'(FA_W) : 64'(FB_W));
        chk($sformatf("r%0d f m_dat", i), m_dat_o, 64'd0);
        chk($sformatf("r%0d f_dat", i), 64'(f_dat_o), v.fa[0] ? 64'hDEAD_BEEF : 64'hCAFE_F00D);
      end
      if (v.ecyc && v.g == G_D) begin
        chk($sformatf("r%0d d m_we", i), 64'(m_we_o), 64'(v.dwe));
        chk($sformatf("r%0d d m_sel", i), 64'(m_sel_o), 64'(DSEL));
        chk($sformatf("r%0d d m_adr", i), 64'(m_adr_o), 64'(DA));
        chk($sformatf("r%0d d m_dat", i), m_dat_o, DD);
      end
    end

    // F in flight is not preempted by a D request
    @(negedge clk_i);
    drive(1'b0, 1'b1, FB, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold f m_cyc", 64'(m_cyc_o), 64'd1);
    chk("hold f m_sel", 64'(m_sel_o), 64'h0F);
    @(negedge clk_i);
    drive(1'b0, 1'b1, FB, 1'b1, 1'b1, 1'b0);
    #1;
    chk("nopreempt m_sel", 64'(m_sel_o), 64'h0F);
    chk("nopreempt m_we", 64'(m_we_o), 64'd0);
    chk("nopreempt d_ack", 64'(d_ack_o), 64'd0);
    @(negedge clk_i);
    drive(1'b0, 1'b1, FB, 1'b1, 1'b1, 1'b1);
    #1;
    chk("f done f_ack", 64'(f_ack_o), 64'd1);
    chk("f done d_ack", 64'(d_ack_o), 64'd0);
    chk("f done f_dat", 64'(f_dat_o), 64'hCAFE_F00D);
    @(negedge clk_i);
    drive(1'b0, 1'b0, FB, 1'b1, 1'b1, 1'b1);
    #1;
    chk("d next d_ack", 64'(d_ack_o), 64'd1);
    chk("d next m_sel", 64'(m_sel_o), 64'(DSEL));
    chk("d next m_we", 64'(m_we_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fd_arbiter.md
# fd_arbiter

Two-master Wishbone arbiter that shares one 64-bit memory port between the Polaris instruction-fetch bus (F-bus, 32-bit, word-addressed) and the data bus (D-bus, 64-bit, dword-addressed). It sits between the fetch stage / load-store unit and the single external Wishbone master port. It arbitrates each transfer separately, gives D priority, and uses a starvation counter to guarantee forward progress for fetch. Zero-wait-state (same-cycle ack) transfers pass through with no added latency.

## Interface

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles F may wait before it takes priority over D. Legal range 1..15.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- f_cyc_i  in  1  fetch request (implies STB, SEL of one 32-bit word).
- f_adr_i  in  [63:2]  fetch word address.
- f_ack_o  out  1  fetch transfer complete.
- f_dat_o  out  [31:0]  fetched instruction word.
- d_cyc_i  in  1  data request (implies STB).
- d_we_i  in  1  data write enable.
- d_sel_i  in  [7:0]  data byte lanes.
- d_adr_i  in  [63:3]  data dword address.
- d_dat_i  in  [63:0]  write data.
- d_ack_o  out  1  data transfer complete.
- d_dat_o  out  [63:0]  read data (m_dat_i passed through).
- m_cyc_o, m_stb_o  out  1  external bus cycle/strobe; always equal.
- m_we_o  out  1  external write enable.
- m_sel_o  out  [7:0]  external byte lanes.
- m_adr_o  out  [63:3]  external address.
- m_dat_o  out  [63:0]  external write data.
- m_ack_i  in  1  external acknowledge; may be asserted in the same cycle as m_cyc_o.
- m_dat_i  in  [63:0]  external read data.

## Operation

- Owner register: states IDLE, BUSY_F, BUSY_D. Reset value IDLE.
- In IDLE, the arbiter selects a master combinationally each cycle:
  - F is selected if f_cyc_i=1 and starve_cnt==STARVE_LIMIT.
  - Otherwise D is selected if d_cyc_i=1.
  - Otherwise F is selected if f_cyc_i=1.
  - Otherwise no master is selected and m_cyc_o=0.
- In BUSY_F and BUSY_D, the latched owner is selected unconditionally. No preemption while a transfer is in flight.
- Transitions:
  - IDLE → BUSY_x when x is selected and m_ack_i=0.
  - IDLE stays IDLE when m_ack_i=1 in the same cycle (single-cycle transfer).
  - BUSY_x → IDLE when m_ack_i=1.
  - BUSY_x → IDLE when the owner's cyc drops (abort). m_cyc_o follows the owner's cyc combinationally, so it drops the same cycle.
- F selected:
  - m_we_o=0, m_dat_o=0, m_adr_o=f_adr_i[63:3].
  - m_sel_o = f_adr_i[2] ? 8'hF0 : 8'h0F.
  - f_dat_o = f_adr_i[2] ? m_dat_i[63:32] : m_dat_i[31:0].
- D selected: m_we_o=d_we_i, m_sel_o=d_sel_i, m_adr_o=d_adr_i, m_dat_o=d_dat_i.
- d_dat_o=m_dat_i at all times.
- Acks: f_ack_o = m_ack_i & m_cyc_o & F selected; d_ack_o likewise for D. An unselected master never sees an ack.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - Cleared when f_cyc_i=0 or f_ack_o=1.
  - Otherwise incremented each cycle while f_cyc_i=1.
- reset_i=1 forces m_cyc_o=0, f_ack_o=0, d_ack_o=0 combinationally that cycle. Next state is owner=IDLE, starve_cnt=0. This applies mid-transfer as well.
- Address, select and data outputs are don't-care while m_cyc_o=0; they are driven 0 when nothing is selected.

## Timing

- Zero added latency: m_* outputs are combinational from the selected master's inputs and the owner register. Acks pass through in the same cycle.
- With an always-acking slave and both masters requesting continuously, the pattern is D,D,D,D,F repeating (for STARVE_LIMIT=4). F gets ≥1 of every STARVE_LIMIT+1 cycles.
- Wait states: the owner is held for N cycles until m_ack_i. Arbitration resumes in the cycle after the ack.
- The selection input change and the owner-latch update happen in the same edge; there is no idle cycle between back-to-back transfers.

## Test plan

- Reset: reset_i=1 for 2 cycles with f_cyc_i=d_cyc_i=m_ack_i=1 → m_cyc_o=0, both acks 0. Cycle after release: D granted.
- Fetch only, m_ack_i=1, f_adr_i=62'h3FFF_FFFF_FFFF_FFC1 → m_sel_o=8'hF0, m_adr_o=f_adr_i[63:3], f_ack_o=1 every cycle, f_dat_o=m_dat_i[63:32].
- Starvation: both requesting, m_ack_i=1, STARVE_LIMIT=4 → d_ack_o on cycles 0–3, f_ack_o on cycle 4, repeating.
- Wait states: D write, m_ack_i low for 3 cycles, F raises f_cyc_i meanwhile → m_we_o=1 and D signals held steady through the ack; F granted the next cycle.
- Abort: BUSY_F, f_cyc_i dropped with m_ack_i=0 → m_cyc_o=0 that cycle; next cycle owner=IDLE and a pending D request is granted.
- Mid-transfer reset: BUSY_D, reset_i=1 → acks 0, m_cyc_o=0; after release, starve_cnt=0 and arbitration restarts from IDLE.
